// File: rtl/vending_pkg.sv
// Shared constants for the change dispenser: coin values, hopper select codes,
// dispenser FSM states and the fault-bit mapping.
package vending_pkg;

  localparam int AMT_W   = 5;
  localparam int COIN_10 = 10;
  localparam int COIN_5  = 5;
  localparam int COIN_1  = 1;

  localparam logic [1:0] HSEL_5  = 2'b00;
  localparam logic [1:0] HSEL_10 = 2'b01;
  localparam logic [1:0] HSEL_1  = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SELECT = 3'd1,
    ST_REQ    = 3'd2,
    ST_GAP    = 3'd3,
    ST_DONE   = 3'd4
  } disp_state_e;

  // Per-denomination flag vectors are ordered {1, 5, 10}.
  function automatic logic [2:0] sel_mask(input logic [1:0] sel);
    case (sel)
      HSEL_10: sel_mask = 3'b001;
      HSEL_5:  sel_mask = 3'b010;
      HSEL_1:  sel_mask = 3'b100;
      default: sel_mask = 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/change_denom_select.sv
// Combinational pick of the largest usable coin for the remaining amount.
// The 1-unit coin is only considered when DISPENSE_ONES_EN is defined.
module change_denom_select #(
  parameter int AMT_W = vending_pkg::AMT_W
) (
  input  logic [AMT_W-1:0] remaining_i,
  input  logic [2:0]       empty_i,
  input  logic [2:0]       fault_i,
  output logic             found_o,
  output logic [1:0]       sel_o,
  output logic [AMT_W-1:0] value_o
);
  import vending_pkg::*;

  localparam logic [AMT_W-1:0] V10 = AMT_W'(COIN_10);
  localparam logic [AMT_W-1:0] V5  = AMT_W'(COIN_5);
  localparam logic [AMT_W-1:0] V1  = AMT_W'(COIN_1);

  logic [2:0] avail;

  always_comb begin
    avail[0] = !empty_i[0] && !fault_i[0] && (remaining_i >= V10);
    avail[1] = !empty_i[1] && !fault_i[1] && (remaining_i >= V5);
`ifdef DISPENSE_ONES_EN
    avail[2] = !empty_i[2] && !fault_i[2] && (remaining_i >= V1);
`else
    avail[2] = 1'b0;
`endif
    found_o = |avail;
    sel_o   = HSEL_5;
    value_o = '0;
    if (avail[0]) begin
      sel_o   = HSEL_10;
      value_o = V10;
    end else if (avail[1]) begin
      sel_o   = HSEL_5;
      value_o = V5;
    end else if (avail[2]) begin
      sel_o   = HSEL_1;
      value_o = V1;
    end
  end

`ifndef DISPENSE_ONES_EN
  logic unused_ones;
  assign unused_ones = empty_i[2] ^ fault_i[2];
`endif

endmodule

// File: rtl/change_dispenser.sv
// Pays out a change amount coin by coin over a req/ack hopper handshake,
// largest coin first. Optional 1-unit coin support via DISPENSE_ONES_EN.
module change_dispenser #(
  parameter int AMT_W       = vending_pkg::AMT_W,
  parameter int ACK_TIMEOUT = 15,
  parameter int GAP_CYCLES  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [AMT_W-1:0] change_amount,
  input  logic             change_valid,
  input  logic             empty10,
  input  logic             empty5,
  input  logic             empty1,
  input  logic             hopper_ack,
  output logic             hopper_req,
  output logic [1:0]       hopper_sel,
  output logic             busy,
  output logic             dispense_done,
  output logic [AMT_W-1:0] dispensed_total,
  output logic [AMT_W-1:0] shortfall,
  output logic [2:0]       state_dbg
);
  import vending_pkg::*;

  // Hopper handshake: hopper_req rises with a stable hopper_sel and stays high
  // until the edge that samples hopper_ack=1 or the timeout expires; one ack = one coin.
  localparam int CNT_MAX = (ACK_TIMEOUT > GAP_CYCLES) ? ACK_TIMEOUT : GAP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] TO_LOAD  = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYCLES - 1);

  disp_state_e      state_q, state_d;
  logic [AMT_W-1:0] rem_q, rem_d, tot_q, tot_d, short_q, short_d, coin_q, coin_d;
  logic [2:0]       fault_q, fault_d;
  logic [1:0]       sel_q, sel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             req_q, busy_q, done_q;

  logic             pick_found;
  logic [1:0]       pick_sel;
  logic [AMT_W-1:0] pick_value;

  change_denom_select #(.AMT_W(AMT_W)) u_pick (
    .remaining_i (rem_q),
    .empty_i     ({empty1, empty5, empty10}),
    .fault_i     (fault_q),
    .found_o     (pick_found),
    .sel_o       (pick_sel),
    .value_o     (pick_value)
  );

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    tot_d   = tot_q;
    short_d = short_q;
    coin_d  = coin_q;
    fault_d = fault_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: if (change_valid) begin
        rem_d   = change_amount;
        tot_d   = '0;
        short_d = '0;
        fault_d = '0;
        state_d = ST_SELECT;
      end
      ST_SELECT: if (rem_q == '0 || !pick_found) begin
        short_d = rem_q;
        state_d = ST_DONE;
      end else begin
        sel_d   = pick_sel;
        coin_d  = pick_value;
        cnt_d   = TO_LOAD;
        state_d = ST_REQ;
      end
      // The counter doubles as the ack timeout here and the idle gap in ST_GAP.
      ST_REQ: if (hopper_ack) begin
        rem_d   = rem_q - coin_q;
        tot_d   = tot_q + coin_q;
        cnt_d   = GAP_LOAD;
        state_d = ST_GAP;
      end else if (cnt_q == '0) begin
        fault_d = fault_q | sel_mask(sel_q);
        cnt_d   = GAP_LOAD;
        state_d = ST_GAP;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
      ST_GAP: if (cnt_q == '0) state_d = ST_SELECT;
              else cnt_d = cnt_q - 1'b1;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      tot_q   <= '0;
      short_q <= '0;
      coin_q  <= '0;
      fault_q <= '0;
      sel_q   <= HSEL_5;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      tot_q   <= tot_d;
      short_q <= short_d;
      coin_q  <= coin_d;
      fault_q <= fault_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      req_q   <= (state_d == ST_REQ);
      busy_q  <= (state_d != ST_IDLE);
      done_q  <= (state_d == ST_DONE);
    end
  end

  assign hopper_req      = req_q;
  assign hopper_sel      = sel_q;
  assign busy            = busy_q;
  assign dispense_done   = done_q;
  assign dispensed_total = tot_q;
  assign shortfall       = short_q;
  assign state_dbg       = state_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Table-driven bench for change_dispenser with a reactive hopper model;
// expectations follow DISPENSE_ONES_EN when it is defined.
module tb_change_dispenser;

  localparam int AMT_W = 5;
  localparam logic [1:0] S5  = 2'b00;
  localparam logic [1:0] S10 = 2'b01;
  localparam logic [1:0] S1  = 2'b10;

  logic             clk = 1'b0;
  logic             rst;
  logic [AMT_W-1:0] change_amount;
  logic             change_valid;
  logic             empty10, empty5, empty1;
  logic             hopper_ack;
  logic             hopper_req;
  logic [1:0]       hopper_sel;
  logic             busy;
  logic             dispense_done;
  logic [AMT_W-1:0] dispensed_total;
  logic [AMT_W-1:0] shortfall;
  logic [2:0]       state_dbg;

  change_dispenser #(.AMT_W(AMT_W), .ACK_TIMEOUT(15), .GAP_CYCLES(2)) dut (
    .clk             (clk),
    .rst             (rst),
    .change_amount   (change_amount),
    .change_valid    (change_valid),
    .empty10         (empty10),
    .empty5          (empty5),
    .empty1          (empty1),
    .hopper_ack      (hopper_ack),
    .hopper_req      (hopper_req),
    .hopper_sel      (hopper_sel),
    .busy            (busy),
    .dispense_done   (dispense_done),
    .dispensed_total (dispensed_total),
    .shortfall       (shortfall),
    .state_dbg       (state_dbg)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    int         amount;
    logic       e10, e5, e1, noack10;
    int         nsel;
    logic [9:0] seq;
    int         total;
    int         short_amt;
    int         first_len;
  } vec_t;

  int         checks = 0;
  int         failures = 0;
  logic [1:0] exp_q[$];
  vec_t       vecs[8];

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input string nm, input int amt, input logic e10, input logic e5,
                              input logic e1, input logic na, input int n, input logic [9:0] seq,
                              input int tot, input int sh, input int flen);
    vec_t v;
    v.name = nm; v.amount = amt; v.e10 = e10; v.e5 = e5; v.e1 = e1; v.noack10 = na;
    v.nsel = n; v.seq = seq; v.total = tot; v.short_amt = sh; v.first_len = flen;
    return v;
  endfunction

  task automatic run_vec(input vec_t v);
    int         cyc, len, first_evt, nruns;
    logic       prev_req, finished;
    logic [1:0] prev_sel, s;
    exp_q.delete();
    for (int i = 0; i < v.nsel; i++) begin
      s = v.seq[2*i +: 2];
      exp_q.push_back(s);
    end
    empty10 = v.e10; empty5 = v.e5; empty1 = v.e1;
    @(negedge clk);
    change_amount = AMT_W'(v.amount);
    change_valid  = 1'b1;
    cyc = 0; len = 0; first_evt = -1; nruns = 0;
    prev_req = 1'b0; prev_sel = 2'b00; finished = 1'b0;
    while (!finished && cyc < 400) begin
      @(negedge clk);
      cyc++;
      change_valid = 1'b0;
      if (hopper_req) begin
        if (!prev_req) begin
          if (first_evt < 0) first_evt = cyc;
          if (exp_q.size() == 0) check({v.name, " extra_req"}, 1, 0);
          else begin
            s = exp_q.pop_front();
            check({v.name, " sel"}, int'(hopper_sel), int'(s));
          end
          len = 1;
        end else begin
          len++;
          if (hopper_sel != prev_sel) check({v.name, " sel_stable"}, int'(hopper_sel), int'(prev_sel));
        end
        hopper_ack = prev_req && !(v.noack10 && hopper_sel == S10);
      end else begin
        hopper_ack = 1'b0;
        if (prev_req) begin
          nruns++;
          if (nruns == 1) check({v.name, " first_req_len"}, len, v.first_len);
        end
      end
      if (dispense_done) begin
        if (first_evt < 0) first_evt = cyc;
        check({v.name, " total"}, int'(dispensed_total), v.total);
        check({v.name, " shortfall"}, int'(shortfall), v.short_amt);
        finished = 1'b1;
      end
      prev_req = hopper_req;
      prev_sel = hopper_sel;
    end
    if (!finished) check({v.name, " done_timeout"}, 0, 1);
    else begin
      @(negedge clk);
      check({v.name, " busy_after_done"}, int'(busy), 0);
      check({v.name, " done_width"}, int'(dispense_done), 0);
    end
    check({v.name, " latency"}, first_evt, 2);
    check({v.name, " leftover_coins"}, exp_q.size(), 0);
  endtask

  initial begin
    int  n;
    logic seen;
    rst = 1'b1; change_amount = '0; change_valid = 1'b0;
    empty10 = 1'b0; empty5 = 1'b0; empty1 = 1'b0; hopper_ack = 1'b0;

    vecs[0] = mk("amt25", 25, 0, 0, 0, 0, 3, 10'({S5, S10, S10}), 25, 0, 2);
    vecs[1] = mk("amt15_e10", 15, 1, 0, 0, 0, 3, 10'({S5, S5, S5}), 15, 0, 2);
    vecs[2] = mk("amt20_to10", 20, 0, 0, 0, 1, 5, 10'({S5, S5, S5, S5, S10}), 20, 0, 15);
`ifdef DISPENSE_ONES_EN
    vecs[3] = mk("amt7", 7, 0, 0, 0, 0, 3, 10'({S1, S1, S5}), 7, 0, 2);
    vecs[5] = mk("amt13_e5", 13, 0, 1, 0, 0, 4, 10'({S1, S1, S1, S10}), 13, 0, 2);
`else
    vecs[3] = mk("amt7", 7, 0, 0, 0, 0, 1, 10'({S5}), 5, 2, 2);
    vecs[5] = mk("amt13_e5", 13, 0, 1, 0, 0, 1, 10'({S10}), 10, 3, 2);
`endif
    vecs[4] = mk("amt0", 0, 0, 0, 0, 0, 0, 10'd0, 0, 0, 0);
    vecs[6] = mk("amt31_all_empty", 31, 1, 1, 1, 0, 0, 10'd0, 0, 31, 0);
    vecs[7] = mk("amt9_e10_e1", 9, 1, 0, 1, 0, 1, 10'({S5}), 5, 4, 2);

    repeat (3) @(negedge clk);
    check("reset_req", int'(hopper_req), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(dispense_done), 0);
    check("reset_state", int'(state_dbg), 0);
    check("reset_total", int'(dispensed_total), 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Mid-transaction reset while a coin request is outstanding.
    empty10 = 1'b0; empty5 = 1'b0; empty1 = 1'b0;
    change_amount = AMT_W'(25); change_valid = 1'b1;
    @(negedge clk);
    change_valid = 1'b0;
    n = 0;
    while (!hopper_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("midrst_req_seen", int'(hopper_req), 1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_req", int'(hopper_req), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_done", int'(dispense_done), 0);
    check("midrst_total", int'(dispensed_total), 0);
    check("midrst_state", int'(state_dbg), 0);
    rst = 1'b0;
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (dispense_done || hopper_req || busy) seen = 1'b1;
    end
    check("midrst_quiet", int'(seen), 0);
    run_vec(vecs[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
